// File: rtl/multi_channel_tester.sv
// Multi-channel link tester: each channel has a pattern generator on the tx stream
// and a self-synchronising checker on the rx stream, with sticky error flags and saturating counters.
module multi_channel_tester #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ERR_CNT_W = 4,
  parameter int unsigned PATTERN   = 0
) (
  input  logic                        clk,
  input  logic                        peripheral_reset,
  input  logic                        enable,
  input  logic                        clear_err,
  input  logic [NUM_CH-1:0]           inject_err,
  input  logic [NUM_CH-1:0]           channel_up,
  output logic [NUM_CH*DATA_W-1:0]    tx_tdata,
  output logic [NUM_CH-1:0]           tx_tvalid,
  input  logic [NUM_CH-1:0]           tx_tready,
  input  logic [NUM_CH*DATA_W-1:0]    rx_tdata,
  input  logic [NUM_CH-1:0]           rx_tvalid,
  output logic [NUM_CH-1:0]           error,
  output logic [NUM_CH*ERR_CNT_W-1:0] error_count,
  output logic [NUM_CH-1:0]           locked
);

  localparam logic [DATA_W-1:0]    SEED    = (PATTERN == 1) ? DATA_W'(1) : '0;
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } state_t;

  function automatic logic [DATA_W-1:0] next_word(input logic [DATA_W-1:0] w);
    if (PATTERN == 1) return {w[DATA_W-2:0], w[DATA_W-1]};
    else              return w + DATA_W'(1);
  endfunction

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic                 go;
    logic                 accept;
    logic                 hold;
    logic                 pend;
    logic                 valid_q;
    logic                 arm_q;
    logic                 cor_q;
    logic [DATA_W-1:0]    pat_q;
    logic [DATA_W-1:0]    pat_next;
    logic [DATA_W-1:0]    data_q;
    logic [DATA_W-1:0]    rx_word;
    logic [DATA_W-1:0]    exp_q;
    logic                 load_exp;
    logic                 do_check;
    logic                 mismatch;
    logic                 err_q;
    logic                 locked_q;
    logic [ERR_CNT_W-1:0] cnt_q;
    state_t               state_q;
    state_t               state_next;

    assign go      = enable & channel_up[i];
    assign accept  = valid_q & tx_tready[i];
    assign hold    = valid_q & ~tx_tready[i];
    assign rx_word = rx_tdata[i*DATA_W +: DATA_W];

    // Corruption still owed: a new pulse, an armed flag, or a corrupted word not yet taken.
    assign pend = arm_q | inject_err[i] | (cor_q & ~accept);

    // Clean pattern value of the word on the bus; restarts from seed while the link is down.
    always_comb begin
      pat_next = pat_q;
      if (!channel_up[i])  pat_next = SEED;
      else if (accept)     pat_next = next_word(pat_q);
    end

    // Generator: output word register carries the injected bit-0 flip, pattern does not.
    always_ff @(posedge clk or posedge peripheral_reset) begin
      if (peripheral_reset) begin
        valid_q <= 1'b0;
        pat_q   <= SEED;
        data_q  <= '0;
        arm_q   <= 1'b0;
        cor_q   <= 1'b0;
      end else begin
        valid_q <= go;
        pat_q   <= pat_next;
        if (!go) begin
          data_q <= '0;
          cor_q  <= 1'b0;
          arm_q  <= pend;
        end else if (!hold) begin
          data_q <= {pat_next[DATA_W-1:1], pat_next[0] ^ pend};
          cor_q  <= pend;
          arm_q  <= 1'b0;
        end else begin
          arm_q  <= arm_q | inject_err[i];
        end
      end
    end

    always_ff @(posedge clk or posedge peripheral_reset) begin
      if (peripheral_reset) state_q <= IDLE;
      else                  state_q <= state_next;
    end

    always_comb begin
      state_next = state_q;
      if (!go) begin
        state_next = IDLE;
      end else begin
        case (state_q)
          IDLE:    state_next = SYNC;
          SYNC:    if (rx_tvalid[i]) state_next = RUN;
          RUN:     state_next = RUN;
          default: state_next = IDLE;
        endcase
      end
    end

    always_comb begin
      load_exp = 1'b0;
      do_check = 1'b0;
      if (go) begin
        case (state_q)
          SYNC:    load_exp = rx_tvalid[i];
          RUN:     do_check = rx_tvalid[i];
          default: ;
        endcase
      end
    end

    assign mismatch = do_check & (rx_word != exp_q);

    // Expected value tracks the pattern, never the received data once running.
    always_ff @(posedge clk or posedge peripheral_reset) begin
      if (peripheral_reset) begin
        exp_q    <= '0;
        locked_q <= 1'b0;
      end else begin
        locked_q <= (state_next == RUN);
        if (load_exp)      exp_q <= next_word(rx_word);
        else if (do_check) exp_q <= next_word(exp_q);
      end
    end

    always_ff @(posedge clk or posedge peripheral_reset) begin
      if (peripheral_reset) begin
        err_q <= 1'b0;
        cnt_q <= '0;
      end else if (clear_err) begin
        err_q <= 1'b0;
        cnt_q <= '0;
      end else if (mismatch) begin
        err_q <= 1'b1;
        if (cnt_q != CNT_MAX) cnt_q <= cnt_q + ERR_CNT_W'(1);
      end
    end

    assign tx_tdata[i*DATA_W +: DATA_W]          = data_q;
    assign tx_tvalid[i]                          = valid_q;
    assign error[i]                              = err_q;
    assign error_count[i*ERR_CNT_W +: ERR_CNT_W] = cnt_q;
    assign locked[i]                             = locked_q;
  end

endmodule

// File: tb/tb_multi_channel_tester.sv
// Directed bench: a counter-pattern tester and a 16-bit walking-ones tester, both in loopback.
module tb_multi_channel_tester;

  logic        clk = 1'b0;
  logic        peripheral_reset;
  logic        enable;
  logic        clear_err;
  logic [1:0]  channel_up;
  logic [1:0]  c_inject, c_ready, c_tvalid, c_error, c_locked;
  logic [63:0] c_tdata;
  logic [7:0]  c_count;
  logic [1:0]  w_inject, w_ready, w_tvalid, w_error, w_locked;
  logic [31:0] w_tdata;
  logic [7:0]  w_count;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_c [2];
  logic [15:0] exp_w [2];

  always #5 clk = ~clk;

  multi_channel_tester #(.NUM_CH(2), .DATA_W(32), .ERR_CNT_W(4), .PATTERN(0)) u_cnt (
    .clk(clk), .peripheral_reset(peripheral_reset), .enable(enable), .clear_err(clear_err),
    .inject_err(c_inject), .channel_up(channel_up), .tx_tdata(c_tdata), .tx_tvalid(c_tvalid),
    .tx_tready(c_ready), .rx_tdata(c_tdata), .rx_tvalid(c_tvalid & c_ready), .error(c_error),
    .error_count(c_count), .locked(c_locked)
  );

  multi_channel_tester #(.NUM_CH(2), .DATA_W(16), .ERR_CNT_W(4), .PATTERN(1)) u_walk (
    .clk(clk), .peripheral_reset(peripheral_reset), .enable(enable), .clear_err(clear_err),
    .inject_err(w_inject), .channel_up(channel_up), .tx_tdata(w_tdata), .tx_tvalid(w_tvalid),
    .tx_tready(w_ready), .rx_tdata(w_tdata), .rx_tvalid(w_tvalid & w_ready), .error(w_error),
    .error_count(w_count), .locked(w_locked)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_status(input string tag, input logic [1:0] err, input logic [7:0] cnt);
    check({tag, "_error"},  64'(c_error),  64'(err));
    check({tag, "_count"},  64'(c_count),  64'(cnt));
    check({tag, "_locked"}, 64'(c_locked), 64'h3);
    check({tag, "_werror"}, 64'(w_error),  64'h0);
    check({tag, "_wcount"}, 64'(w_count),  64'h0);
  endtask

  initial begin
    peripheral_reset = 1'b1;
    enable = 1'b0; clear_err = 1'b0; channel_up = 2'b00;
    c_inject = 2'b00; w_inject = 2'b00; c_ready = 2'b11; w_ready = 2'b11;
    #1;
    check("reset_tvalid", 64'(c_tvalid), 64'h0);
    check("reset_tdata",  c_tdata,       64'h0);
    check("reset_count",  64'(c_count),  64'h0);
    check("reset_locked", 64'(c_locked), 64'h0);
    check("reset_wtdata", 64'(w_tdata),  64'h0);

    // Release reset with link up but generation disabled: bus must stay quiet.
    cyc(3);
    peripheral_reset = 1'b0;
    channel_up = 2'b11;
    cyc(4);
    check("idle_tvalid", 64'(c_tvalid), 64'h0);
    check("idle_tdata",  c_tdata,       64'h0);
    check("idle_wtdata", 64'(w_tdata),  64'h0);
    check("idle_locked", 64'(c_locked), 64'h0);

    enable = 1'b1;
    cyc(1);
    check("first_tvalid", 64'(c_tvalid), 64'h3);
    check("first_word",   c_tdata,       64'h0);
    check("first_wword",  64'(w_tdata),  64'h0001_0001);
    check("sync_locked",  64'(c_locked), 64'h0);
    cyc(1);
    check("second_word",  c_tdata,       {32'd1, 32'd1});
    check("second_wword", 64'(w_tdata),  64'h0002_0002);
    check("run_locked",   64'(c_locked), 64'h3);
    check("run_wlocked",  64'(w_locked), 64'h3);

    // Long loopback run.
    cyc(998);
    check("loop_word",  c_tdata,      {32'd999, 32'd999});
    check("loop_wword", 64'(w_tdata), 64'h0080_0080);
    check_status("loop", 2'b00, 8'h00);

    // Channel 0 link drop for 10 cycles.
    channel_up = 2'b10;
    cyc(1);
    check("drop_locked", 64'(c_locked), 64'h2);
    check("drop_tvalid", 64'(c_tvalid), 64'h2);
    check("drop_tdata0", 64'(c_tdata[31:0]), 64'h0);
    cyc(9);
    channel_up = 2'b11;
    cyc(1);
    check("resync_word",   64'(c_tdata[31:0]), 64'h0);
    check("resync_locked", 64'(c_locked), 64'h2);
    cyc(1);
    check("relock_word", c_tdata, {32'd1011, 32'd1});
    check_status("relock", 2'b00, 8'h00);
    cyc(21);
    check("pre_inj_word", c_tdata, {32'd1032, 32'd22});

    // Injection on ch1: corrupted word, error one cycle later, pattern unaffected.
    c_inject = 2'b10;
    cyc(1);
    c_inject = 2'b00;
    check("inj_word",    c_tdata,       {32'd1032, 32'd23});
    check("inj_nolat",   64'(c_error),  64'h0);
    cyc(1);
    check("inj_next",    c_tdata,       {32'd1034, 32'd24});
    check_status("inj1", 2'b10, 8'h10);
    cyc(48);
    for (int k = 0; k < 2; k++) begin
      c_inject = 2'b10;
      cyc(1);
      c_inject = 2'b00;
      cyc(49);
    end
    check_status("inj3", 2'b10, 8'h30);

    // Two pulses while ch1 is stalled inject only once.
    c_ready = 2'b01;
    c_inject = 2'b10; cyc(1); c_inject = 2'b00; cyc(1);
    c_inject = 2'b10; cyc(1); c_inject = 2'b00; cyc(1);
    check("stall_word",  64'(c_tdata[63:32]), 64'd1182);
    check("stall_count", 64'(c_count), 64'h30);
    c_ready = 2'b11;
    cyc(3);
    check("multi_word", 64'(c_tdata[63:32]), 64'd1185);
    check_status("multi", 2'b10, 8'h40);

    // Saturation on ch0, then clear.
    for (int k = 0; k < 20; k++) begin
      c_inject = 2'b01;
      cyc(1);
      c_inject = 2'b00;
      cyc(3);
    end
    check_status("sat", 2'b11, 8'h4F);
    cyc(10);
    check_status("sat_hold", 2'b11, 8'h4F);
    clear_err = 1'b1;
    cyc(1);
    clear_err = 1'b0;
    check_status("clear", 2'b00, 8'h00);

    // clear_err on the same edge as a mismatch wins.
    c_inject = 2'b01; cyc(1); c_inject = 2'b00; cyc(2);
    check_status("one_err", 2'b01, 8'h01);
    c_inject = 2'b01;
    cyc(1);
    c_inject = 2'b00;
    clear_err = 1'b1;
    cyc(1);
    clear_err = 1'b0;
    check_status("clr_win", 2'b00, 8'h00);
    cyc(4);
    check_status("clr_win_hold", 2'b00, 8'h00);

    // Reset mid-stream: outputs drop without a clock edge.
    c_inject = 2'b01; cyc(1); c_inject = 2'b00; cyc(2);
    check_status("pre_rst", 2'b01, 8'h01);
    #2 peripheral_reset = 1'b1;
    #1;
    check("arst_tvalid", 64'(c_tvalid), 64'h0);
    check("arst_tdata",  c_tdata,       64'h0);
    check("arst_error",  64'(c_error),  64'h0);
    check("arst_count",  64'(c_count),  64'h0);
    check("arst_locked", 64'(c_locked), 64'h0);
    check("arst_wtdata", 64'(w_tdata),  64'h0);
    @(negedge clk);
    peripheral_reset = 1'b0;
    cyc(1);
    check("rst_first_word",  c_tdata,       64'h0);
    check("rst_first_wword", 64'(w_tdata),  64'h0001_0001);
    check("rst_tvalid",      64'(c_tvalid), 64'h3);
    cyc(1);
    check("rst_second_word", c_tdata, {32'd1, 32'd1});
    check_status("rst_relock", 2'b00, 8'h00);

    // Random backpressure against a pattern model.
    exp_c[0] = 32'd1; exp_c[1] = 32'd1;
    exp_w[0] = 16'h0002; exp_w[1] = 16'h0002;
    for (int k = 0; k < 2000; k++) begin
      c_ready = 2'($urandom);
      w_ready = 2'($urandom);
      cyc(1);
      for (int ch = 0; ch < 2; ch++) begin
        if (c_ready[ch]) exp_c[ch] = exp_c[ch] + 32'd1;
        if (w_ready[ch]) exp_w[ch] = {exp_w[ch][14:0], exp_w[ch][15]};
      end
      check("bp_cword", c_tdata, {exp_c[1], exp_c[0]});
      check("bp_wword", 64'(w_tdata), 64'({exp_w[1], exp_w[0]}));
    end
    c_ready = 2'b11;
    w_ready = 2'b11;
    cyc(5);
    check_status("bp_end", 2'b00, 8'h00);
    check("bp_wlocked", 64'(w_locked), 64'h3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_channel_tester.md
MULTI_CHANNEL_TESTER -- requirements
Module: multi_channel_tester

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent link channels, legal range 1-4.
REQ-002 Parameter DATA_W, default 32: data width per channel, legal values 16, 32 or 64.
REQ-003 Parameter ERR_CNT_W, default 4: width of each per-channel error counter, legal range 4-16.
REQ-004 Parameter PATTERN, default 0: 0 selects an incrementing counter; 1 selects walking-ones (rotate left by 1, seed 1).
REQ-005 clk  in  1  single clock for all logic.
REQ-006 peripheral_reset  in  1  asynchronous, active-high reset.
REQ-007 enable  in  1  enables generation and checking on all channels.
REQ-008 clear_err  in  1  synchronous pulse; clears all error counters and sticky flags.
REQ-009 inject_err  in  NUM_CH  per-channel pulse; inverts bit 0 of the next transmitted word.
REQ-010 channel_up  in  NUM_CH  per-channel link-up indication.
REQ-011 tx_tdata  out  NUM_CH*DATA_W  generator data; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-012 tx_tvalid  out  NUM_CH  generator valid, one bit per channel.
REQ-013 tx_tready  in  NUM_CH  sink ready, one bit per channel.
REQ-014 rx_tdata  in  NUM_CH*DATA_W  received data, same packing as tx_tdata.
REQ-015 rx_tvalid  in  NUM_CH  received valid, one bit per channel; there is no backpressure on receive.
REQ-016 error  out  NUM_CH  sticky per-channel mismatch flag.
REQ-017 error_count  out  NUM_CH*ERR_CNT_W  per-channel saturating mismatch count.
REQ-018 locked  out  NUM_CH  per-channel flag; high while the checker is in RUN.

Function
REQ-019 Each channel SHALL contain an independent generator and checker; channels SHALL NOT interact except through the shared enable and clear_err inputs.
REQ-020 Generator: tx_tvalid[i] SHALL equal enable & channel_up[i], registered with one cycle of delay.
REQ-021 Generator: the word SHALL advance only on a cycle where tx_tvalid and tx_tready are both high; tdata SHALL be held stable while valid is high and ready is low.
REQ-022 Generator: the pattern SHALL restart from its seed (counter 0, walking-ones 1) on the cycle channel_up[i] falls.
REQ-023 Generator: the counter pattern SHALL wrap from all-ones to 0, and walking-ones SHALL wrap from the MSB back to bit 0.
REQ-024 Generator: an inject_err[i] pulse SHALL arm a flag, and the next accepted word SHALL be sent with bit 0 inverted.
REQ-025 Generator: the injected corruption SHALL NOT alter the pattern sequence, and the armed flag SHALL clear on acceptance; multiple pulses before acceptance SHALL inject only once.
REQ-026 Checker FSM states and transitions: IDLE -> SYNC when enable & channel_up[i] are both high.
REQ-027 Checker FSM: SYNC -> RUN on the first rx_tvalid beat, loading expected = next(rx_tdata) with no error check on that beat.
REQ-028 Checker FSM: RUN SHALL compare each rx_tvalid beat against expected, then set expected = next(expected), so the checker does not follow corrupted data.
REQ-029 Checker FSM: any state SHALL go to IDLE within 1 cycle when channel_up[i] or enable falls.
REQ-030 Checker: a mismatch in RUN SHALL set error[i] and increment error_count[i] by 1 on the following edge (latency 1).
REQ-031 Checker: error_count[i] SHALL saturate at 2^ERR_CNT_W-1.
REQ-032 Checker: error and error_count SHALL persist through link loss and through IDLE.
REQ-033 clear_err: on the same edge as a mismatch, clear_err SHALL win, leaving count 0 and error 0.
REQ-034 locked[i] SHALL be high only in RUN.

Reset
REQ-035 On assertion of peripheral_reset, all outputs SHALL be 0 immediately: tx_tvalid, tx_tdata, error, error_count and locked.
REQ-036 On reset, checkers SHALL go to IDLE, generators SHALL return to their seed, and armed inject flags SHALL clear.
REQ-037 Deassertion of peripheral_reset SHALL take effect on the next clk edge, with no output activity before enable & channel_up are both high.
REQ-038 Reset asserted mid-stream SHALL discard in-flight state without generating an error count.

Verification
REQ-039 Loopback: NUM_CH=2, DATA_W=32, PATTERN=0, tx looped to rx, ready=1, enable=1, channel_up=11 for 1000 cycles -> locked=11, error=00, error_count=0 on both channels.
REQ-040 Injection: 3 inject_err pulses on ch1, spaced 50 cycles apart -> error=10, error_count ch1=3, ch0=0, locked stays 11.
REQ-041 Saturation: ERR_CNT_W=4, 20 injections on ch0 -> count=15 and holds; clear_err pulse -> count=0, error=0.
REQ-042 Backpressure: random tx_tready at 50% duty for 2000 cycles -> tdata stable while stalled, no errors, walking-ones wraps MSB to bit 0 without error.
REQ-043 Link drop: channel_up[0] low for 10 cycles mid-stream, then high -> locked[0] drops within 1 cycle, resyncs on the first beat, no new errors, ch1 unaffected.
REQ-044 Reset: peripheral_reset asserted during traffic -> all outputs 0 without waiting for a clk edge; after release, traffic restarts from 0.
